// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing, colour bar table and counter sizing helper
package vga_pkg;
  localparam int VGA_RES_X = 640;
  localparam int VGA_H_FP = 16;
  localparam int VGA_H_PULSE = 96;
  localparam int VGA_H_BP = 48;
  localparam int VGA_RES_Y = 480;
  localparam int VGA_V_FP = 10;
  localparam int VGA_V_PULSE = 2;
  localparam int VGA_V_BP = 33;
  localparam int VGA_BARS = 8;
  // 3-bit {r,g,b} flags, entry 0 (white) in the low bits, entry 7 (black) on top
  localparam logic [3*VGA_BARS-1:0] BAR_TABLE = {
    3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
  };

  function automatic logic [2:0] bar_flags(input logic [2:0] idx);
    return BAR_TABLE[3*int'(idx) +: 3];
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/vga_test_bars.sv
// vga_test_bars: eight vertical colour bars, registered, stepped by a width counter
module vga_test_bars import vga_pkg::*; #(
  parameter int C_resolution_x = VGA_RES_X,
  parameter int C_bits_x = 12,
  parameter int C_bits_color = 8
) (
  input  logic                    clk_pixel,
  input  logic                    reset,
  input  logic [C_bits_x-1:0]     x,
  input  logic                    act,
  output logic [C_bits_color-1:0] r,
  output logic [C_bits_color-1:0] g,
  output logic [C_bits_color-1:0] b
);
  localparam int W = C_resolution_x / VGA_BARS;
  localparam int CW = clog2(W) < 1 ? 1 : clog2(W);
  localparam logic [C_bits_x-1:0] X_LAST = C_bits_x'(C_resolution_x - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  logic [CW-1:0] cnt;
  logic [3:0] idx;
  logic [2:0] f;
  assign f = idx[3] ? 3'b000 : bar_flags(idx[2:0]);
  // cnt/idx describe the current pixel; idx saturates at 8 so remainder pixels stay black
  always_ff @(posedge clk_pixel)
    if (reset || !act || x == X_LAST) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= idx + 4'(!idx[3]);
    end else
      cnt <= cnt + CW'(1);
  // one-cycle registered colour for the current pixel, black outside the active area
  always_ff @(posedge clk_pixel)
    if (reset) begin
      r <= '0;
      g <= '0;
      b <= '0;
    end else begin
      r <= act ? {C_bits_color{f[2]}} : '0;
      g <= act ? {C_bits_color{f[1]}} : '0;
      b <= act ? {C_bits_color{f[0]}} : '0;
    end
endmodule

// File: rtl/vga_scan.sv
// vga_scan: parametrised VGA timing generator with FIFO fetch, pixel doubling and frame irq
module vga_scan import vga_pkg::*; #(
  parameter int C_resolution_x = VGA_RES_X,
  parameter int C_hsync_front_porch = VGA_H_FP,
  parameter int C_hsync_pulse = VGA_H_PULSE,
  parameter int C_hsync_back_porch = VGA_H_BP,
  parameter int C_resolution_y = VGA_RES_Y,
  parameter int C_vsync_front_porch = VGA_V_FP,
  parameter int C_vsync_pulse = VGA_V_PULSE,
  parameter int C_vsync_back_porch = VGA_V_BP,
  parameter int C_hsync_polarity = 1,
  parameter int C_vsync_polarity = 1,
  parameter int C_bits_color = 8,
  parameter int C_dbl_x = 0,
  parameter int C_dbl_y = 0,
  parameter int C_bits_x = 12,
  parameter int C_bits_y = 11,
  parameter int C_bits_frame = 16
) (
  input  logic                    clk_pixel,
  input  logic                    reset,
  input  logic                    test_picture,
  output logic                    fetch_next,
  output logic                    line_repeat,
  output logic [C_bits_x-1:0]     beam_x,
  output logic [C_bits_y-1:0]     beam_y,
  output logic [C_bits_frame-1:0] frame_count,
  input  logic [C_bits_color-1:0] red_byte,
  input  logic [C_bits_color-1:0] green_byte,
  input  logic [C_bits_color-1:0] blue_byte,
  output logic [C_bits_color-1:0] vga_r,
  output logic [C_bits_color-1:0] vga_g,
  output logic [C_bits_color-1:0] vga_b,
  output logic                    vga_hsync,
  output logic                    vga_vsync,
  output logic                    vga_vblank,
  output logic                    vga_blank,
  output logic                    vblank_irq
);
  localparam int FRAME_X = C_resolution_x + C_hsync_front_porch + C_hsync_pulse + C_hsync_back_porch;
  localparam int FRAME_Y = C_resolution_y + C_vsync_front_porch + C_vsync_pulse + C_vsync_back_porch;
  localparam logic [C_bits_x-1:0] X_LAST = C_bits_x'(FRAME_X - 1);
  localparam logic [C_bits_x-1:0] X_RES = C_bits_x'(C_resolution_x);
  localparam logic [C_bits_x-1:0] HS_ON = C_bits_x'(C_resolution_x + C_hsync_front_porch);
  localparam logic [C_bits_x-1:0] HS_OFF = C_bits_x'(C_resolution_x + C_hsync_front_porch + C_hsync_pulse);
  localparam logic [C_bits_y-1:0] Y_LAST = C_bits_y'(FRAME_Y - 1);
  localparam logic [C_bits_y-1:0] Y_RES = C_bits_y'(C_resolution_y);
  localparam logic [C_bits_y-1:0] VS_ON = C_bits_y'(C_resolution_y + C_vsync_front_porch);
  localparam logic [C_bits_y-1:0] VS_OFF = C_bits_y'(C_resolution_y + C_vsync_front_porch + C_vsync_pulse);
  localparam logic HS_ACT = 1'(C_hsync_polarity);
  localparam logic VS_ACT = 1'(C_vsync_polarity);
  logic [C_bits_x-1:0] x;
  logic [C_bits_y-1:0] y;
  logic act, hs, vs_line, vb_start, test_q;
  logic [C_bits_color-1:0] pix_r, pix_g, pix_b, bar_r, bar_g, bar_b;
  assign act = x < X_RES && y < Y_RES;
  assign fetch_next = act && (C_dbl_x == 0 || !x[0]);
  assign line_repeat = C_dbl_y != 0 && x == HS_ON && y < Y_RES && !y[0];
  assign hs = x >= HS_ON && x < HS_OFF;
  assign vs_line = y >= VS_ON && y < VS_OFF;
  assign vb_start = x == '0 && y == Y_RES;
  assign beam_x = x;
  assign beam_y = y;
  assign vga_r = test_q ? bar_r : pix_r;
  assign vga_g = test_q ? bar_g : pix_g;
  assign vga_b = test_q ? bar_b : pix_b;
  // beam counters; Y advances on X wrap, both wrap together at the frame corner
  always_ff @(posedge clk_pixel)
    if (reset) begin
      x <= '0;
      y <= '0;
    end else begin
      x <= x == X_LAST ? '0 : x + C_bits_x'(1);
      if (x == X_LAST) y <= y == Y_LAST ? '0 : y + C_bits_y'(1);
    end
  // registered video and timing outputs, all one cycle behind the counters
  always_ff @(posedge clk_pixel)
    if (reset) begin
      vga_hsync <= ~HS_ACT;
      vga_vsync <= ~VS_ACT;
      vga_vblank <= 1'b0;
      vga_blank <= 1'b1;
      vblank_irq <= 1'b0;
      frame_count <= '0;
      test_q <= 1'b0;
      pix_r <= '0;
      pix_g <= '0;
      pix_b <= '0;
    end else begin
      vga_hsync <= hs ? HS_ACT : ~HS_ACT;
      if (x == HS_ON) vga_vsync <= vs_line ? VS_ACT : ~VS_ACT;
      vga_vblank <= y >= Y_RES;
      vga_blank <= !act;
      vblank_irq <= vb_start;
      frame_count <= frame_count + C_bits_frame'(vb_start);
      test_q <= test_picture;
      pix_r <= act ? (fetch_next ? red_byte : pix_r) : '0;
      pix_g <= act ? (fetch_next ? green_byte : pix_g) : '0;
      pix_b <= act ? (fetch_next ? blue_byte : pix_b) : '0;
    end

  vga_test_bars #(
    .C_resolution_x(C_resolution_x),
    .C_bits_x(C_bits_x),
    .C_bits_color(C_bits_color)
  ) u_bars (
    .clk_pixel(clk_pixel),
    .reset(reset),
    .x(x),
    .act(act),
    .r(bar_r),
    .g(bar_g),
    .b(bar_b)
  );
endmodule

// File: tb/tb_vga_scan.sv
// tb_vga_scan: directed checks of three vga_scan configurations on a 14x7 frame
module tb_vga_scan;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int irq_seen = 0;
  int irq_base;
  logic [7:0] rbits = 8'b00110011;
  logic [7:0] gbits = 8'b00001111;
  logic [7:0] bbits = 8'b01010101;

  logic [11:0] x0, x1, x2;
  logic [10:0] y0, y1, y2;
  logic [15:0] fc0, fc1, fc2;
  logic f0, f1, f2, lr0, lr1, lr2;
  logic hs0, hs1, hs2, vs0, vs1, vs2, vb0, vb1, vb2, bl0, bl1, bl2, irq0, irq1, irq2;
  logic [7:0] r0, g0, b0, r1, g1, b1, red1;
  logic [9:0] r2, g2, b2;
  assign red1 = 8'(x1 >> 1);

  vga_scan #(.C_resolution_x(8), .C_hsync_front_porch(2), .C_hsync_pulse(2), .C_hsync_back_porch(2),
    .C_resolution_y(4), .C_vsync_front_porch(1), .C_vsync_pulse(1), .C_vsync_back_porch(1)) u0 (
    .clk_pixel(clk), .reset(reset), .test_picture(1'b0), .fetch_next(f0), .line_repeat(lr0),
    .beam_x(x0), .beam_y(y0), .frame_count(fc0), .red_byte(8'(x0)), .green_byte(8'h5A), .blue_byte(8'hA5),
    .vga_r(r0), .vga_g(g0), .vga_b(b0), .vga_hsync(hs0), .vga_vsync(vs0), .vga_vblank(vb0),
    .vga_blank(bl0), .vblank_irq(irq0));

  vga_scan #(.C_resolution_x(8), .C_hsync_front_porch(2), .C_hsync_pulse(2), .C_hsync_back_porch(2),
    .C_resolution_y(4), .C_vsync_front_porch(1), .C_vsync_pulse(1), .C_vsync_back_porch(1),
    .C_dbl_x(1), .C_dbl_y(1)) u1 (
    .clk_pixel(clk), .reset(reset), .test_picture(1'b0), .fetch_next(f1), .line_repeat(lr1),
    .beam_x(x1), .beam_y(y1), .frame_count(fc1), .red_byte(red1), .green_byte(8'h00), .blue_byte(8'h00),
    .vga_r(r1), .vga_g(g1), .vga_b(b1), .vga_hsync(hs1), .vga_vsync(vs1), .vga_vblank(vb1),
    .vga_blank(bl1), .vblank_irq(irq1));

  vga_scan #(.C_resolution_x(8), .C_hsync_front_porch(2), .C_hsync_pulse(2), .C_hsync_back_porch(2),
    .C_resolution_y(4), .C_vsync_front_porch(1), .C_vsync_pulse(1), .C_vsync_back_porch(1),
    .C_hsync_polarity(0), .C_bits_color(10)) u2 (
    .clk_pixel(clk), .reset(reset), .test_picture(1'b1), .fetch_next(f2), .line_repeat(lr2),
    .beam_x(x2), .beam_y(y2), .frame_count(fc2), .red_byte(10'h155), .green_byte(10'h155), .blue_byte(10'h155),
    .vga_r(r2), .vga_g(g2), .vga_b(b2), .vga_hsync(hs2), .vga_vsync(vs2), .vga_vblank(vb2),
    .vga_blank(bl2), .vblank_irq(irq2));

  always @(negedge clk) if (irq0 === 1'b1) irq_seen <= irq_seen + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic goto(input int gx, input int gy);
    int n = 0;
    while (!(int'(x0) == gx && int'(y0) == gy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("reach_%0d_%0d", gx, gy), 32'(n < 200), 32'd1);
  endtask

  initial begin
    repeat (3) step();
    chk("rst_x", 32'(x0), 0);
    chk("rst_y", 32'(y0), 0);
    chk("rst_fc", 32'(fc0), 0);
    chk("rst_r", 32'(r0), 0);
    chk("rst_blank", 32'(bl0), 1);
    chk("rst_vblank", 32'(vb0), 0);
    chk("rst_irq", 32'(irq0), 0);
    chk("rst_hs", 32'(hs0), 0);
    chk("rst_hs_neg", 32'(hs2), 1);
    chk("rst_vs", 32'(vs0), 0);
    chk("rst_r2", 32'(r2), 0);
    reset = 1'b0;
    for (int n = 0; n < 14; n++) begin
      automatic bit in = n >= 1 && n <= 8;
      automatic int k = in ? n - 1 : 0;
      automatic bit hs = n == 11 || n == 12;
      chk($sformatf("x_%0d", n), 32'(x0), 32'(n));
      chk($sformatf("fetch0_%0d", n), 32'(f0), 32'(n < 8));
      chk($sformatf("fetch1_%0d", n), 32'(f1), 32'(n < 8 && n % 2 == 0));
      chk($sformatf("lrep_%0d", n), 32'(lr1), 32'(n == 10));
      chk($sformatf("r0_%0d", n), 32'(r0), in ? 32'(k) : 0);
      chk($sformatf("g0_%0d", n), 32'(g0), in ? 32'h5A : 0);
      chk($sformatf("blank_%0d", n), 32'(bl0), 32'(!in));
      chk($sformatf("r1_%0d", n), 32'(r1), in ? 32'(k >> 1) : 0);
      chk($sformatf("hs0_%0d", n), 32'(hs0), 32'(hs));
      chk($sformatf("hs2_%0d", n), 32'(hs2), 32'(!hs));
      chk($sformatf("bar_r_%0d", n), 32'(r2), (in && rbits[k]) ? 32'h3FF : 0);
      chk($sformatf("bar_g_%0d", n), 32'(g2), (in && gbits[k]) ? 32'h3FF : 0);
      chk($sformatf("bar_b_%0d", n), 32'(b2), (in && bbits[k]) ? 32'h3FF : 0);
      step();
    end
    chk("y_after_line0", 32'(y0), 1);
    goto(10, 1);
    chk("lrep_y1", 32'(lr1), 0);
    goto(10, 2);
    chk("lrep_y2", 32'(lr1), 1);
    goto(10, 3);
    chk("lrep_y3", 32'(lr1), 0);
    goto(13, 3);
    step();
    chk("wrap_x", 32'(x0), 0);
    chk("wrap_y", 32'(y0), 4);
    chk("vb_pre", 32'(vb0), 0);
    chk("irq_pre", 32'(irq0), 0);
    step();
    chk("vb_first", 32'(vb0), 1);
    chk("irq_first", 32'(irq0), 1);
    chk("fc_first", 32'(fc0), 1);
    step();
    chk("irq_once", 32'(irq0), 0);
    chk("vb_hold", 32'(vb0), 1);
    chk("fc_hold", 32'(fc0), 1);
    goto(10, 5);
    chk("vs_before", 32'(vs0), 0);
    step();
    chk("vs_on", 32'(vs0), 1);
    chk("hs_on_y5", 32'(hs0), 1);
    goto(10, 6);
    chk("vs_still", 32'(vs0), 1);
    step();
    chk("vs_off", 32'(vs0), 0);
    goto(13, 6);
    step();
    chk("corner_x", 32'(x0), 0);
    chk("corner_y", 32'(y0), 0);
    chk("corner_vb", 32'(vb0), 1);
    step();
    chk("vb_clear", 32'(vb0), 0);
    chk("f2_r0", 32'(r0), 0);
    goto(1, 4);
    chk("irq_f2", 32'(irq0), 1);
    chk("fc_f2", 32'(fc0), 2);
    goto(5, 6);
    chk("fc_two", 32'(fc0), 2);
    chk("irq_count", 32'(irq_seen), 2);
    goto(5, 2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_x", 32'(x0), 0);
    chk("mid_y", 32'(y0), 0);
    chk("mid_blank", 32'(bl0), 1);
    chk("mid_fc", 32'(fc0), 0);
    chk("mid_irq", 32'(irq0), 0);
    irq_base = irq_seen;
    goto(0, 4);
    chk("mid_no_irq", 32'(irq_seen - irq_base), 0);
    chk("mid_fc_zero", 32'(fc0), 0);
    step();
    chk("mid_irq_l4", 32'(irq0), 1);
    chk("mid_fc_one", 32'(fc0), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vga_scan.md
# vga_scan

Parametrised successor of the VGA timing generator, with a synchronous reset, configurable sync polarity and colour width, real X/Y pixel doubling, and a frame counter with a vblank interrupt pulse. It sits between the pixel FIFO (show-ahead, `clk_pixel` domain) and the DVI/HDMI encoder. Every video output is registered, and all of them share one latency relative to the beam counters.

## Interface
Parameters:
- `C_resolution_x`, 640: active pixels per line
- `C_hsync_front_porch` / `C_hsync_pulse` / `C_hsync_back_porch`, 16 / 96 / 48: horizontal blanking segments
- `C_resolution_y`, 480: active lines
- `C_vsync_front_porch` / `C_vsync_pulse` / `C_vsync_back_porch`, 10 / 2 / 33: vertical blanking segments
- `C_hsync_polarity`, `C_vsync_polarity`, 1 / 1: active level of the sync pulse (1 = active-high)
- `C_bits_color`, 8: bits per colour channel
- `C_dbl_x`, `C_dbl_y`, 0 / 0: 1 = each source pixel / line is shown twice
- `C_bits_x`, `C_bits_y`, `C_bits_frame`, 12 / 11 / 16: counter widths

Ports:
- `clk_pixel` in 1: pixel clock
- `reset` in 1: synchronous, active-high
- `test_picture` in 1: 1 selects the internal colour bars
- `fetch_next` out 1: consume current FIFO word
- `line_repeat` out 1: FIFO rewinds to start of last line
- `beam_x` / `beam_y` out `C_bits_x` / `C_bits_y`: raw counters
- `frame_count` out `C_bits_frame`: completed frames
- `red_byte` / `green_byte` / `blue_byte` in `C_bits_color`: FIFO head data
- `vga_r` / `vga_g` / `vga_b` out `C_bits_color`: video
- `vga_hsync`, `vga_vsync`, `vga_vblank`, `vga_blank`, `vblank_irq` out 1 each

## Operation
- **Counters.** `frame_x` = sum of the horizontal parameters; `frame_y` = sum of the vertical parameters.
  - X wraps at `frame_x-1`. Y increments on each X wrap and wraps at `frame_y-1`.
  - `beam_x` and `beam_y` are the counters themselves (combinational from registers).
- **Active area.** `act` = X < `C_resolution_x` and Y < `C_resolution_y`.
- **Fetch.** `fetch_next` = `act` and (`C_dbl_x`=0 or X[0]=0). It is combinational from the counters.
  - The FIFO head is sampled on the edge that ends each `fetch_next` cycle.
  - With `C_dbl_x`=1 the sampled word is held for 2 pixels.
- **Line repeat.** With `C_dbl_y`=1, `line_repeat` is a 1-cycle pulse when X = `C_resolution_x`+`C_hsync_front_porch`, Y < `C_resolution_y` and Y[0]=0, so odd lines replay the even line. With `C_dbl_y`=0 it is constantly 0.
- **Test picture.** 8 vertical bars, each `C_resolution_x`/8 wide (elaboration-time integer division), in the order white, yellow, cyan, green, magenta, red, blue, black.
  - Full scale is all ones of `C_bits_color`.
  - Remainder pixels at the right edge are black.
  - The bar index comes from a width counter, not a divider.
- **Blanking.** Video is forced to 0 whenever the delayed `act` is 0.
- **Horizontal sync.** Active while X is in [`C_resolution_x`+`C_hsync_front_porch`, +`C_hsync_pulse`).
- **Vertical sync.** Active for lines [`C_resolution_y`+`C_vsync_front_porch`, +`C_vsync_pulse`). It changes only at the hsync leading edge.
- **Vertical blank.** `vga_vblank` = Y ≥ `C_resolution_y`.
- **Frame counter and interrupt.**
  - `vblank_irq` pulses for exactly 1 cycle, coincident with the first cycle `vga_vblank`=1.
  - `frame_count` increments in that same cycle and wraps modulo 2^`C_bits_frame`.

## Timing
- **Latency.** `vga_r/g/b`, `vga_hsync`, `vga_vsync`, `vga_vblank`, `vga_blank` and `vblank_irq` are all registered. All lag the counter state by exactly 1 cycle, so sync and pixel stay aligned.
- **Pixel data.** The pixel sampled while X=n appears on `vga_*` in the cycle the counters read n+1.
- **Reset values** (first cycle after `reset` deasserts, counters at 0):
  - X, Y and `frame_count` = 0.
  - `vga_r/g/b` = 0, `vga_blank` = 1, `vga_vblank` = 0, `vblank_irq` = 0.
  - Syncs at their inactive level (`~C_*_polarity`).
- **Reset mid-frame.** Reset aborts the frame immediately. No `vblank_irq` or `frame_count` increment is produced for the aborted frame. The FIFO is reset externally, by its owner.
- **Simultaneous wrap.** At X = `frame_x-1` and Y = `frame_y-1`, both counters return to 0 on the same edge.
- **Minimum parameters.** `C_*_pulse` ≥ 1, porches ≥ 1, `C_resolution_x` ≥ 8, and even resolutions when doubling.

## Structure
- Package `vga_pkg` holds:
  - the default 640x480@60 timing constants;
  - the 8-entry bar colour table, as 3-bit RGB flags expanded to `C_bits_color`;
  - a `clog2` helper for sizing counters.
- One natural sub-module, `vga_test_bars`: it takes X, the active flag and `clk_pixel`, and outputs one registered RGB triple. The top module keeps the counters, syncs, fetch logic and output mux.

## Test plan
Bench parameters: 8x4 active, h porches 2/2/2, v porches 1/1/1, giving a 14x7 frame.
- **Reset then free-run for 2 frames.** `beam_x` wraps at 13 and `beam_y` at 6. `vga_hsync` is high for 2 cycles when X reads 11–12. `vga_vsync` is high during line 5. `vblank_irq` fires exactly twice. `frame_count` = 2.
- **Fetch, `C_dbl_x`=0, FIFO data = X.** `fetch_next` is high 8 cycles per active line. `vga_r` shows 0..7, one cycle after each fetch.
- **Fetch, `C_dbl_x`=1, `C_dbl_y`=1.** `fetch_next` is high 4 times per line. `vga_r` shows 0,0,1,1,2,2,3,3. `line_repeat` pulses on lines 0 and 2 at X=10.
- **Polarity and colour width, `C_hsync_polarity`=0, `C_bits_color`=10, `test_picture`=1.** `vga_hsync` idles at 1 and pulses low. Line 0 shows bar values 0x3FF white … 0 black, one bar per pixel.
- **Reset asserted at Y=2, X=5 for 1 cycle.** Next cycle: counters = 0 and `vga_blank`=1. No `vblank_irq` is produced before line 4 of the new frame, and `frame_count` stays 0.
